// File: rtl/mac_tile_pkg.sv
// rtl/mac_tile_pkg.sv - shared constants and types for the multi-lane MAC tile
// Purpose : instruction bit positions, mode encodings and kernel-load FSM states.
// Ports   : none (package).
package mac_tile_pkg;

    // Bit positions inside the 3-bit instruction word
    localparam int INST_OS   = 2;
    localparam int INST_EXEC = 1;
    localparam int INST_KF   = 0;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic {
        K_READY = 1'b0,
        K_HELD  = 1'b1
    } kstate_t;

endpackage

// File: rtl/mac_tile_mc_lanes.sv
// rtl/mac_tile_mc_lanes.sv - combinational LANES-wide signed dot product plus addend
// Purpose : mac_o = c_i + sum_l a_i[l]*b_i[l], wrapping at PSUM_BW, or saturating when
//           MAC_TILE_SAT_EN is defined.
// Ports   : a_i, b_i  packed signed lanes (lane l = [l*BW +: BW])
//           c_i       signed addend
//           mac_o     signed result
import mac_tile_pkg::*;

module mac_lanes #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 2
) (
    input  logic [LANES*BW-1:0] a_i,
    input  logic [LANES*BW-1:0] b_i,
    input  logic [PSUM_BW-1:0]  c_i,
    output logic [PSUM_BW-1:0]  mac_o
);

`ifdef MAC_TILE_SAT_EN
    // Wide enough that the true sum never overflows before clamping
    localparam int EXT_BW = PSUM_BW + 2*BW + LANES;
    localparam logic signed [EXT_BW-1:0] SAT_MAX = EXT_BW'(signed'({1'b0, {(PSUM_BW-1){1'b1}}}));
    localparam logic signed [EXT_BW-1:0] SAT_MIN = EXT_BW'(signed'({1'b1, {(PSUM_BW-1){1'b0}}}));
`else
    // Wrapping result only needs the low PSUM_BW bits of every term
    localparam int EXT_BW = PSUM_BW;
`endif

    logic signed [EXT_BW-1:0] acc;

    always_comb begin
        acc = EXT_BW'(signed'(c_i));
        for (int l = 0; l < LANES; l++) begin
            acc = acc + EXT_BW'(signed'(a_i[l*BW +: BW])) * EXT_BW'(signed'(b_i[l*BW +: BW]));
        end
    end

`ifdef MAC_TILE_SAT_EN
    always_comb begin
        if (acc > SAT_MAX) begin
            mac_o = {1'b0, {(PSUM_BW-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            mac_o = {1'b1, {(PSUM_BW-1){1'b0}}};
        end else begin
            mac_o = acc[PSUM_BW-1:0];
        end
    end
`else
    assign mac_o = acc;
`endif

endmodule

// File: rtl/mac_tile_mc.sv
// rtl/mac_tile_mc.sv - reconfigurable OS/WS multi-lane systolic MAC tile
// Purpose : one array node. Activations/instructions move west->east, psums/OS weights
//           move north->south. WS mode has a one-shot kernel-load FSM; OS mode accumulates
//           with a fresh start per execute burst and supports flush through the psum chain.
//           Optional saturation: define MAC_TILE_SAT_EN.
// Ports   : clk, reset_n (sync, active-low)
//           in_w / out_e      activations or kernel weights in, registered activations out
//           inst_w / inst_e   instruction in, registered instruction out
//           in_n / out_s      psum / packed weights / flush data in, result out
//           kernel_ready      WS FSM is waiting for a kernel
import mac_tile_pkg::*;

module mac_tile_mc #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [LANES*BW-1:0] in_w,
    output logic [LANES*BW-1:0] out_e,
    input  logic [2:0]          inst_w,
    output logic [2:0]          inst_e,
    input  logic [PSUM_BW-1:0]  in_n,
    output logic [PSUM_BW-1:0]  out_s,
    output logic                kernel_ready
);

    if (LANES*BW > PSUM_BW) begin : g_bw_check
        $error("mac_tile_mc: LANES*BW must not exceed PSUM_BW");
    end

    logic [LANES*BW-1:0] a_q, a_d;
    logic [LANES*BW-1:0] b_q, b_d;
    logic [PSUM_BW-1:0]  c_q, c_d;
    logic [2:0]          inst_q, inst_d;
    logic                mode_q, mode_d;
    logic                first_q, first_d;
    kstate_t             kstate_q, kstate_d;

    logic [PSUM_BW-1:0]  mac_c;
    logic [PSUM_BW-1:0]  mac_out;
    logic                act_load;

    // First accumulate of an OS burst adds to zero instead of the stale c_q
    assign mac_c = (mode_q == MODE_OS && first_q) ? '0 : c_q;

    mac_lanes #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW),
        .LANES   (LANES)
    ) u_lanes (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_i   (mac_c),
        .mac_o (mac_out)
    );

    assign act_load = inst_w[INST_EXEC] | inst_w[INST_KF];

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        inst_d   = inst_w;
        mode_d   = mode_q;
        kstate_d = kstate_q;
        first_d  = first_q;

        if (inst_w[INST_OS] != mode_q) begin
            // Mode switch: clear weights/accumulator, re-arm kernel load, drop exec/kload
            mode_d   = inst_w[INST_OS];
            b_d      = '0;
            c_d      = '0;
            kstate_d = K_READY;
            inst_d   = {inst_w[INST_OS], 2'b00};
            first_d  = 1'b1;
        end else begin
            if (act_load) begin
                a_d = in_w;
            end
            if (mode_q == MODE_WS) begin
                if (act_load) begin
                    c_d = in_n;
                end
                // Only the first kload after reset/switch is consumed here; later ones pass east
                if (inst_w[INST_KF] && kstate_q == K_READY) begin
                    b_d              = in_w;
                    kstate_d         = K_HELD;
                    inst_d[INST_KF]  = 1'b0;
                end
            end else begin
                if (inst_w[INST_EXEC]) begin
                    b_d = in_n[LANES*BW-1:0];
                end
                if (inst_q[INST_EXEC]) begin
                    c_d     = mac_out;
                    first_d = 1'b0;
                end else begin
                    first_d = 1'b1;
                end
                // Flush wins over a same-cycle accumulate
                if (inst_w[INST_KF]) begin
                    c_d = in_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            inst_q   <= '0;
            mode_q   <= MODE_WS;
            kstate_q <= K_READY;
            first_q  <= 1'b1;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            inst_q   <= inst_d;
            mode_q   <= mode_d;
            kstate_q <= kstate_d;
            first_q  <= first_d;
        end
    end

    assign out_e        = a_q;
    assign inst_e       = inst_q;
    assign kernel_ready = (kstate_q == K_READY);

    always_comb begin
        if (mode_q == MODE_WS) begin
            out_s = mac_out;
        end else if (inst_w[INST_EXEC]) begin
            out_s = PSUM_BW'(b_q);
        end else begin
            out_s = c_q;
        end
    end

endmodule

// File: tb/tb_mac_tile_mc.sv
// tb/tb_mac_tile_mc.sv - self-checking bench for mac_tile_mc (LANES=2, BW=4, PSUM_BW=16)
module tb_mac_tile_mc;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LANES   = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_w    = '0;
    logic [2:0]  inst_w  = '0;
    logic [15:0] in_n    = '0;
    logic [7:0]  out_e;
    logic [2:0]  inst_e;
    logic [15:0] out_s;
    logic        kernel_ready;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mac_tile_mc #(.BW(BW), .PSUM_BW(PSUM_BW), .LANES(LANES)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_w         (in_w),
        .out_e        (out_e),
        .inst_w       (inst_w),
        .inst_e       (inst_e),
        .in_n         (in_n),
        .out_s        (out_s),
        .kernel_ready (kernel_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state: integer lanes, integer accumulator
    int         ma [2];
    int         mb [2];
    int         mc;
    logic [2:0] minst;
    bit         mmode;
    bit         mheld;
    bit         mfirst;

    function automatic int sx4(input logic [3:0] v);
        return int'(signed'(v));
    endfunction

    function automatic int sx16(input logic [15:0] v);
        return int'(signed'(v));
    endfunction

    function automatic int fit16(input longint x);
        logic signed [15:0] t;
`ifdef MAC_TILE_SAT_EN
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
`endif
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int dot();
        return ma[0]*mb[0] + ma[1]*mb[1];
    endfunction

    function automatic logic [15:0] exp_out_s();
        if (!mmode) return 16'(fit16(longint'(mc) + longint'(dot())));
        if (inst_w[1]) return {8'h00, 4'(mb[1]), 4'(mb[0])};
        return 16'(mc);
    endfunction

    task automatic model_update();
        int d;
        logic [2:0] ni;
        d  = dot();
        ni = inst_w;
        if (!reset_n) begin
            ma = '{0, 0}; mb = '{0, 0}; mc = 0; minst = '0;
            mmode = 1'b0; mheld = 1'b0; mfirst = 1'b1;
        end else if (inst_w[2] != mmode) begin
            mmode = inst_w[2]; mb = '{0, 0}; mc = 0; mheld = 1'b0;
            minst = {inst_w[2], 2'b00}; mfirst = 1'b1;
        end else begin
            if (!mmode) begin
                if (inst_w[1] | inst_w[0]) mc = sx16(in_n);
                if (inst_w[0] && !mheld) begin
                    mb[0] = sx4(in_w[3:0]); mb[1] = sx4(in_w[7:4]);
                    mheld = 1'b1; ni[0] = 1'b0;
                end
            end else begin
                if (minst[1]) mc = mfirst ? d : fit16(longint'(mc) + longint'(d));
                mfirst = !minst[1];
                if (inst_w[0]) mc = sx16(in_n);
                if (inst_w[1]) begin
                    mb[0] = sx4(in_n[3:0]); mb[1] = sx4(in_n[7:4]);
                end
            end
            if (inst_w[1] | inst_w[0]) begin
                ma[0] = sx4(in_w[3:0]); ma[1] = sx4(in_w[7:4]);
            end
            minst = ni;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_e",        16'(out_e),        {8'h00, 4'(ma[1]), 4'(ma[0])});
            check("inst_e",       16'(inst_e),       16'(minst));
            check("kernel_ready", 16'(kernel_ready), 16'(!mheld));
            check("out_s",        out_s,             exp_out_s());
        end
    end

    task automatic drive(input logic r, input logic [2:0] i, input logic [7:0] w, input logic [15:0] n);
        reset_n = r; inst_w = i; in_w = w; in_n = n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input logic r, input logic [2:0] i, input logic [7:0] w, input logic [15:0] n);
        drive(r, i, w, n);
        tick();
    endtask

    task automatic look(input logic r, input logic [2:0] i, input logic [7:0] w, input logic [15:0] n);
        drive(r, i, w, n);
        @(negedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b0, 3'b000, 8'h00, 16'h0000);
        cyc(1'b0, 3'b000, 8'h00, 16'h0000);
        chk_en = 1'b1;

        // Reset state
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("rst_out_e", 16'(out_e), 16'h0000);
        check("rst_inst_e", 16'(inst_e), 16'h0000);
        check("rst_out_s", out_s, 16'h0000);
        check("rst_kready", 16'(kernel_ready), 16'h0001);
        tick();

        // WS kernel load {3,-2}, then a second kload passes east
        cyc(1'b1, 3'b001, 8'h3E, 16'h0000);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("kload_kready", 16'(kernel_ready), 16'h0000);
        check("kload_consumed", 16'(inst_e), 16'h0000);
        tick();
        cyc(1'b1, 3'b001, 8'h77, 16'h0000);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("kload_pass", 16'(inst_e), 16'h0001);
        tick();

        // WS execute: 100 + 2*3 + 5*(-2) = 96 (kernel not overwritten by {7,7})
        cyc(1'b1, 3'b010, 8'h25, 16'd100);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("ws_psum96", out_s, 16'd96);
        check("ws_out_e", 16'(out_e), 16'h0025);
        tick();

        // WS execute: -16 + (-1)*3 + 7*(-2) = -33
        cyc(1'b1, 3'b010, 8'hF7, 16'hFFF0);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("ws_psum_neg", out_s, 16'hFFDF);
        tick();

        // Switch to OS: exec ignored, state cleared, a held
        cyc(1'b1, 3'b110, 8'h11, 16'h0005);
        look(1'b1, 3'b100, 8'h00, 16'h0000);
        check("sw_kready", 16'(kernel_ready), 16'h0001);
        check("sw_inst_e", 16'(inst_e), 16'h0004);
        check("sw_a_held", 16'(out_e), 16'h00F7);
        check("sw_c_clear", out_s, 16'h0000);
        tick();

        // OS burst of 3 executes: 3 * (3*1 + 4*2) = 33
        cyc(1'b1, 3'b110, 8'h34, 16'h0012);
        cyc(1'b1, 3'b110, 8'h34, 16'h0012);
        cyc(1'b1, 3'b110, 8'h34, 16'h0012);
        cyc(1'b1, 3'b100, 8'h00, 16'h0000);
        look(1'b1, 3'b101, 8'h00, 16'd7);
        check("os_acc33", out_s, 16'd33);
        tick();
        look(1'b1, 3'b100, 8'h00, 16'h0000);
        check("os_flushed", out_s, 16'd7);
        tick();

        // Second burst starts fresh: 11, not 18
        look(1'b1, 3'b110, 8'h34, 16'h0012);
        check("os_wpass", out_s, 16'h0012);
        tick();
        cyc(1'b1, 3'b100, 8'h00, 16'h0000);
        look(1'b1, 3'b100, 8'h00, 16'h0000);
        check("os_fresh11", out_s, 16'd11);
        tick();

        // Overflow: exec+flush loads 32760 mid-burst, next product adds (-1)(-8)+(-3)(-1)=11
        cyc(1'b1, 3'b110, 8'h34, 16'h0012);
        cyc(1'b1, 3'b111, 8'hDF, 16'h7FF8);
        cyc(1'b1, 3'b100, 8'h00, 16'h0000);
        look(1'b1, 3'b100, 8'h00, 16'h0000);
`ifdef MAC_TILE_SAT_EN
        check("os_overflow", out_s, 16'h7FFF);
`else
        check("os_overflow", out_s, 16'h8003);
`endif
        tick();

        // Reset in the middle of an OS accumulate
        cyc(1'b1, 3'b110, 8'h34, 16'h0012);
        cyc(1'b0, 3'b110, 8'h34, 16'h0012);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("mid_rst_out_e", 16'(out_e), 16'h0000);
        check("mid_rst_inst_e", 16'(inst_e), 16'h0000);
        check("mid_rst_out_s", out_s, 16'h0000);
        check("mid_rst_kready", 16'(kernel_ready), 16'h0001);
        tick();

        // Kernel reload after reset: b={1,2}, a={1,1}, psum 1 -> 1+1+2 = 4
        cyc(1'b1, 3'b001, 8'h12, 16'h0000);
        cyc(1'b1, 3'b010, 8'h11, 16'h0001);
        look(1'b1, 3'b000, 8'h00, 16'h0000);
        check("reload_psum", out_s, 16'd4);
        tick();
        cyc(1'b1, 3'b000, 8'h00, 16'h0000);
        cyc(1'b1, 3'b000, 8'h00, 16'h0000);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
